instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder/loader for LEGv8 instruction words; the inverse of the opcode-to-control decoder.
- Accepts symbolic instruction requests (operation, register numbers, immediate) over a valid/ready stream.
- Encodes each request into a 32-bit R-, D- or CB-format word and writes it sequentially into instruction memory through a req/ack write port.
- Used by the bench/boot path to load programs before the datapath runs.

Parameters:
ADDR_W, 8, width of the instruction-memory byte address
BASE_ADDR, 0, byte address of the first instruction written after start
MAX_INSTR, 64, maximum instructions per load session (1..2^(ADDR_W-2))

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  one-cycle pulse; begins a load session (honoured only in IDLE)
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid & in_ready
in_op  input  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 illegal
in_rd  input  5  Rd (R-format) or Rt (D/CB-format)
in_rn  input  5  Rn
in_rm  input  5  Rm (R-format only)
in_imm  input  19  D-format uses [8:0]; CBZ uses [18:0]
in_last  input  1  marks final request of the session
mem_we  output  1  write request to instruction memory
mem_addr  output  ADDR_W  byte address of write
mem_wdata  output  32  encoded instruction word
mem_ack  input  1  memory accepted the write this cycle
instr_count  output  ADDR_W  instructions written this session
done  output  1  one-cycle pulse at session end
err_illegal  output  1  sticky; an in_op=7 request was consumed
err_full  output  1  sticky; session ended because MAX_INSTR was reached without in_last

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0; mem_addr=BASE_ADDR.
- Encodings:
  - R-format: {opc[10:0], Rm, shamt=6'b0, Rn, Rd}, with opc ADD=10001011000, SUB=11001011000, AND=10001010000, ORR=10101010000.
  - D-format: {opc, imm[8:0], 2'b00, Rn, Rt}, with opc LDUR=11111000010, STUR=11111000000.
  - CBZ: {8'b10110100, imm[18:0], Rt}.
  - Unused input bits are ignored.
- States: IDLE, RUN, WRITE, FIN.
- IDLE:
  - in_ready=0.
  - start=1 -> RUN; clears instr_count, err_illegal and err_full; mem_addr=BASE_ADDR.
- RUN:
  - in_ready=1.
  - On handshake with a legal op: register the encoded word into mem_wdata -> WRITE. mem_we=1 from the next cycle.
  - On handshake with op 7: word discarded; err_illegal set; stay RUN, or go to FIN if in_last=1.
- WRITE:
  - in_ready=0. mem_we, mem_addr and mem_wdata are held stable until mem_ack=1.
  - On ack: mem_we drops next cycle; instr_count+1; mem_addr+4 (wraps modulo 2^ADDR_W).
  - Next state:
    - FIN if the pending request had in_last.
    - Otherwise FIN if the new count == MAX_INSTR, with err_full set.
    - Otherwise RUN.
- FIN: done=1 for exactly one cycle -> IDLE. instr_count, mem_addr and the error flags hold until the next start.
- Throughput: 1 instruction per 2 cycles minimum (accept, then write with same-cycle ack). mem_ack outside WRITE is ignored.
- start outside IDLE is ignored.
- The in_last request that hits MAX_INSTR ends the session without setting err_full.
- rst_n low mid-WRITE: mem_we drops immediately; the session is abandoned.

Test Plan:
- Reset, start, ADD rd=1 rn=2 rm=3 in_last=1, mem_ack same cycle -> mem_wdata=0x8B030041 at mem_addr=0x00; done pulse; instr_count=1.
- LDUR rt=5 rn=6 imm=8 then CBZ rt=9 imm=4 (last) -> writes 0xF84080C5 @0x00, then 0xB4000089 @0x04; done once.
- STUR with mem_ack delayed 3 cycles -> mem_we/addr/data stable 4 cycles; in_ready=0 throughout; no extra write.
- in_op=7 among two ADDs -> only 2 writes at 0x00 and 0x04; err_illegal=1; instr_count=2.
- MAX_INSTR=2, three requests without in_last -> 2 writes, done pulse, err_full=1, third request not accepted.
- rst_n pulsed low while mem_we=1 -> mem_we=0 asynchronously; IDLE; instr_count=0; later start works normally.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes LEGv8 requests (R/D/CB) and writes them to imem.
// Ports: start/in_* request stream, mem_* write port, instr_count/done/err_* status.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_INSTR = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [18:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] instr_count,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WRITE,
    FIN
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] MAXC = ADDR_W'(MAX_INSTR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  state_t            state;
  state_t            state_nx;
  logic              hs;
  logic              legal;
  logic              last_q;
  logic              hit_max;
  logic [31:0]       enc;
  logic [ADDR_W-1:0] cnt_inc;

  assign hs      = in_valid && in_ready;
  assign legal   = (in_op != 3'd7);
  assign cnt_inc = instr_count + 1'b1;
  assign hit_max = (cnt_inc == MAXC);

  always_comb begin
    enc = 32'b0;
    unique case (1'b1)
      in_op == 3'd0: enc = {11'b10001011000, in_rm, 6'b0, in_rn, in_rd};
      in_op == 3'd1: enc = {11'b11001011000, in_rm, 6'b0, in_rn, in_rd};
      in_op == 3'd2: enc = {11'b10001010000, in_rm, 6'b0, in_rn, in_rd};
      in_op == 3'd3: enc = {11'b10101010000, in_rm, 6'b0, in_rn, in_rd};
      in_op == 3'd4: enc = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
      in_op == 3'd5: enc = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
      in_op == 3'd6: enc = {8'b10110100, in_imm, in_rd};
      default:       enc = 32'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        if (hs && legal)        state_nx = WRITE;
        else if (hs && in_last) state_nx = FIN;
      end
      WRITE: begin
        if (mem_ack) begin
          if (last_q || hit_max) state_nx = FIN;
          else                   state_nx = RUN;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN);
    mem_we   = (state == WRITE);
    done     = (state == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wdata   <= 32'b0;
      mem_addr    <= BASE;
      instr_count <= '0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mem_addr    <= BASE;
            instr_count <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
          end
        end
        RUN: begin
          if (hs && legal) begin
            mem_wdata <= enc;
            last_q    <= in_last;
          end else if (hs) begin
            err_illegal <= 1'b1;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            instr_count <= cnt_inc;
            mem_addr    <= mem_addr + STEP;
            // a final request landing exactly on the limit is a clean end
            if (!last_q && hit_max) err_full <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of encoding, handshakes and status.
// u1 uses default parameters, u2 uses MAX_INSTR=2 for the limit cases.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start2;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rn;
  logic [4:0]  in_rm;
  logic [18:0] in_imm;
  logic        in_last;
  logic        mem_ack;

  logic        in_ready, mem_we, done, err_illegal, err_full;
  logic [7:0]  mem_addr, instr_count;
  logic [31:0] mem_wdata;

  logic        in_ready2, mem_we2, done2, err_illegal2, err_full2;
  logic [7:0]  mem_addr2, instr_count2;
  logic [31:0] mem_wdata2;

  int checks = 0;
  int errors = 0;
  int nwr    = 0;
  int ndone  = 0;

  always #5 clk = ~clk;

  instr_encoder_loader u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn),
    .in_rm(in_rm), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .instr_count(instr_count), .done(done),
    .err_illegal(err_illegal), .err_full(err_full)
  );

  instr_encoder_loader #(.MAX_INSTR(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn),
    .in_rm(in_rm), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_ack(mem_ack),
    .instr_count(instr_count2), .done(done2),
    .err_illegal(err_illegal2), .err_full(err_full2)
  );

  always @(posedge clk) begin
    if (mem_we && mem_ack) nwr++;
    if (done) ndone++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input bit two);
    if (two) start2 = 1'b1;
    else     start  = 1'b1;
    tick;
    start  = 1'b0;
    start2 = 1'b0;
    nwr    = 0;
    ndone  = 0;
  endtask

  task automatic send(input bit two, input logic [2:0] op,
                      input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [18:0] imm,
                      input logic last);
    in_op    = op;
    in_rd    = rd;
    in_rn    = rn;
    in_rm    = rm;
    in_imm   = imm;
    in_last  = last;
    in_valid = 1'b1;
    if (two) chk("send_rdy2", in_ready2, 1);
    else     chk("send_rdy", in_ready, 1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] d,
                    input logic [7:0] a, input int dly);
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_data"}, mem_wdata, d);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_rdy"}, in_ready, 0);
    for (int i = 0; i < dly; i++) begin
      tick;
      chk({tag, "_we_hold"}, mem_we, 1);
      chk({tag, "_data_hold"}, mem_wdata, d);
      chk({tag, "_addr_hold"}, mem_addr, a);
      chk({tag, "_rdy_hold"}, in_ready, 0);
    end
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    start2   = 1'b0;
    in_valid = 1'b0;
    in_op    = '0;
    in_rd    = '0;
    in_rn    = '0;
    in_rm    = '0;
    in_imm   = '0;
    in_last  = 1'b0;
    mem_ack  = 1'b0;
    #12;
    chk("rst_rdy", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_wdata, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_done", done, 0);
    chk("rst_eill", err_illegal, 0);
    chk("rst_efull", err_full, 0);
    rst_n = 1'b1;
    tick;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("idle_ack_ign", mem_we, 0);

    // single ADD, same-cycle ack
    go(0);
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0, 1'b1);
    wr("add", 32'h8B030041, 8'h00, 0);
    chk("t1_done", done, 1);
    chk("t1_cnt", instr_count, 1);
    chk("t1_we_off", mem_we, 0);
    tick;
    chk("t1_done_off", done, 0);
    chk("t1_cnt_hold", instr_count, 1);
    chk("t1_addr_hold", mem_addr, 8'h04);

    // LDUR then CBZ
    go(0);
    chk("t2_cnt_clr", instr_count, 0);
    chk("t2_addr_clr", mem_addr, 0);
    send(0, 3'd4, 5'd5, 5'd6, 5'd0, 19'd8, 1'b0);
    wr("ldur", 32'hF84080C5, 8'h00, 0);
    chk("t2_mid_done", done, 0);
    chk("t2_mid_rdy", in_ready, 1);
    send(0, 3'd6, 5'd9, 5'd0, 5'd0, 19'd4, 1'b1);
    wr("cbz", 32'hB4000089, 8'h04, 0);
    chk("t2_done", done, 1);
    chk("t2_cnt", instr_count, 2);
    tick;
    tick;
    chk("t2_ndone", ndone, 1);
    chk("t2_nwr", nwr, 2);

    // STUR with delayed ack, high imm bits must be ignored
    go(0);
    send(0, 3'd5, 5'd7, 5'd8, 5'd0, 19'h7FFFF, 1'b1);
    wr("stur", 32'hF81FF107, 8'h00, 3);
    chk("t3_done", done, 1);
    tick;
    tick;
    chk("t3_nwr", nwr, 1);
    chk("t3_cnt", instr_count, 1);

    // illegal op between two legal ops
    go(0);
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0);
    wr("add2", 32'h8B030041, 8'h00, 0);
    send(0, 3'd7, 5'd1, 5'd1, 5'd1, 19'd0, 1'b0);
    chk("t4_ill_rdy", in_ready, 1);
    chk("t4_ill_we", mem_we, 0);
    chk("t4_eill", err_illegal, 1);
    send(0, 3'd3, 5'd4, 5'd5, 5'd6, 19'd0, 1'b1);
    wr("orr", 32'hAA0600A4, 8'h04, 0);
    chk("t4_done", done, 1);
    chk("t4_cnt", instr_count, 2);
    chk("t4_eill_hold", err_illegal, 1);
    tick;
    chk("t4_nwr", nwr, 2);

    // remaining R ops, illegal op as the last request
    go(0);
    chk("t5_eill_clr", err_illegal, 0);
    send(0, 3'd1, 5'd31, 5'd31, 5'd31, 19'd0, 1'b0);
    wr("sub", 32'hCB1F03FF, 8'h00, 0);
    send(0, 3'd2, 5'd0, 5'd1, 5'd2, 19'd0, 1'b0);
    wr("and", 32'h8A020020, 8'h04, 1);
    send(0, 3'd7, 5'd0, 5'd0, 5'd0, 19'd0, 1'b1);
    chk("t5_ill_done", done, 1);
    chk("t5_cnt", instr_count, 2);
    chk("t5_eill", err_illegal, 1);
    tick;

    // MAX_INSTR=2 without in_last
    go(1);
    chk("t6_rdy", in_ready2, 1);
    chk("t6_u1_idle", in_ready, 0);
    send(1, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0);
    chk("t6_we", mem_we2, 1);
    chk("t6_data", mem_wdata2, 32'h8B030041);
    chk("t6_addr", mem_addr2, 8'h00);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("t6_cnt1", instr_count2, 1);
    send(1, 3'd2, 5'd0, 5'd1, 5'd2, 19'd0, 1'b0);
    chk("t6_addr2", mem_addr2, 8'h04);
    chk("t6_data2", mem_wdata2, 32'h8A020020);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("t6_done", done2, 1);
    chk("t6_efull", err_full2, 1);
    chk("t6_cnt2", instr_count2, 2);
    in_op    = 3'd1;
    in_valid = 1'b1;
    chk("t6_rdy_fin", in_ready2, 0);
    tick;
    chk("t6_rdy_idle", in_ready2, 0);
    tick;
    in_valid = 1'b0;
    chk("t6_no_we", mem_we2, 0);
    chk("t6_cnt_hold", instr_count2, 2);

    // MAX_INSTR=2 with in_last on the second: no err_full
    go(1);
    chk("t7_efull_clr", err_full2, 0);
    send(1, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0);
    mem_ack = 1'b1;
    tick;
    send(1, 3'd1, 5'd1, 5'd2, 5'd3, 19'd0, 1'b1);
    tick;
    mem_ack = 1'b0;
    chk("t7_done", done2, 1);
    chk("t7_efull", err_full2, 0);
    chk("t7_cnt", instr_count2, 2);
    tick;

    // reset in the middle of a write
    go(0);
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0);
    wr("pre_rst", 32'h8B030041, 8'h00, 0);
    send(0, 3'd4, 5'd5, 5'd6, 5'd0, 19'd8, 1'b0);
    chk("t8_we_pre", mem_we, 1);
    chk("t8_cnt_pre", instr_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_we_async", mem_we, 0);
    chk("t8_rdy", in_ready, 0);
    chk("t8_cnt", instr_count, 0);
    chk("t8_addr", mem_addr, 0);
    #1 rst_n = 1'b1;
    tick;
    chk("t8_idle", in_ready, 0);
    go(0);
    send(0, 3'd6, 5'd9, 5'd0, 5'd0, 19'd4, 1'b1);
    wr("post_rst", 32'hB4000089, 8'h00, 0);
    chk("t8_done", done, 1);
    chk("t8_cnt_post", instr_count, 1);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
